psram_ctrl_apb: RTL and testbench

APB completer that turns 32-bit CPU loads/stores into QPI transactions on the external PSRAM pins (sck, ce_n, dio[3:0]). It sits between the SoC APB fabric and the PSRAM device, owning command/address serialisation, read-wait counting, nibble sampling and byte-lane packing. It handles one transaction at a time and holds the APB bus in wait states until the PSRAM burst completes.

---
 rtl/psram_ctrl_apb.sv | 218 +++++++++++++++++++++
 tb/tb_psram_ctrl_apb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_ctrl_apb.sv
// APB completer that maps 32-bit loads/stores onto QPI PSRAM bursts.
// One transfer at a time; the APB bus is held in wait states until the
// burst finishes. sck runs at half the system clock while ce_n is low.
module psram_ctrl_apb #(
    parameter int ADDR_BITS = 24,
    parameter int RD_WAIT   = 7
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        sck,
    output logic        ce_n,
    output logic [3:0]  dio_o,
    output logic        dio_oe,
    input  logic [3:0]  dio_i
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WAIT,
        RDATA,
        WDATA,
        DONE
    } state_t;

    localparam logic [7:0] ADDR_NIB = 8'(ADDR_BITS / 4);
    localparam logic [7:0] WAIT_LIM = 8'(RD_WAIT);

    state_t state, state_next;

    logic                 phase;      // current sck level inside a burst
    logic [7:0]           cnt;        // pulse index within the current state
    logic [7:0]           pulse_lim;
    logic                 last;       // high phase of the final pulse of a state
    logic                 active;
    logic                 start;
    logic                 is_wr;
    logic                 err;
    logic [2:0]           wr_cnt;     // number of byte lanes to write
    logic [7:0]           cmd_sr;
    logic [ADDR_BITS-1:0] addr_sr;
    logic [31:0]          wd_sr;
    logic [31:0]          rd_sr;
    logic [5:0]           dec;
    logic                 dec_ok;
    logic [1:0]           dec_start;
    logic [2:0]           dec_cnt;
    logic                 unused_ok;

    // Contiguous-strobe decode: {ok, start lane, lane count}. Zero strobe is
    // legal with a count of zero; any gap in the strobes is rejected.
    function automatic logic [5:0] strb_decode(input logic [3:0] s);
        case (s)
            4'b0000: return {1'b1, 2'd0, 3'd0};
            4'b0001: return {1'b1, 2'd0, 3'd1};
            4'b0010: return {1'b1, 2'd1, 3'd1};
            4'b0100: return {1'b1, 2'd2, 3'd1};
            4'b1000: return {1'b1, 2'd3, 3'd1};
            4'b0011: return {1'b1, 2'd0, 3'd2};
            4'b0110: return {1'b1, 2'd1, 3'd2};
            4'b1100: return {1'b1, 2'd2, 3'd2};
            4'b0111: return {1'b1, 2'd0, 3'd3};
            4'b1110: return {1'b1, 2'd1, 3'd3};
            4'b1111: return {1'b1, 2'd0, 3'd4};
            default: return {1'b0, 2'd0, 3'd0};
        endcase
    endfunction

    // Byte reversal: wire order is first byte first, APB lanes are little-endian.
    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    assign dec       = strb_decode(pstrb);
    assign dec_ok    = dec[5];
    assign dec_start = dec[4:3];
    assign dec_cnt   = dec[2:0];
    assign start     = (state == IDLE) && psel && penable;
    assign active    = (state == CMD) || (state == ADDR) || (state == WAIT) ||
                       (state == RDATA) || (state == WDATA);
    assign last      = phase && (cnt == pulse_lim - 8'd1);
    assign unused_ok = &{1'b0, paddr[31:ADDR_BITS], paddr[1:0]};

    // Number of sck pulses spent in each burst state.
    always_comb begin
        pulse_lim = 8'd1;
        case (state)
            CMD:     pulse_lim = 8'd8;
            ADDR:    pulse_lim = ADDR_NIB;
            WAIT:    pulse_lim = WAIT_LIM;
            RDATA:   pulse_lim = 8'd8;
            WDATA:   pulse_lim = {4'b0000, wr_cnt, 1'b0};
            default: pulse_lim = 8'd1;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and pin/bus output decode.
    always_comb begin
        state_next = state;
        ce_n       = 1'b1;
        sck        = 1'b0;
        dio_oe     = 1'b0;
        dio_o      = 4'h0;
        pready     = 1'b0;
        pslverr    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (pwrite && (!dec_ok || dec_cnt == 3'd0)) state_next = DONE;
                    else                                        state_next = CMD;
                end
            end
            CMD: begin
                ce_n   = 1'b0;
                sck    = phase;
                dio_oe = 1'b1;
                dio_o  = {3'b000, cmd_sr[7]};
                if (last) state_next = ADDR;
            end
            ADDR: begin
                ce_n   = 1'b0;
                sck    = phase;
                dio_oe = 1'b1;
                dio_o  = addr_sr[ADDR_BITS-1 -: 4];
                if (last) begin
                    if (is_wr)             state_next = WDATA;
                    else if (RD_WAIT == 0) state_next = RDATA;
                    else                   state_next = WAIT;
                end
            end
            WAIT: begin
                ce_n = 1'b0;
                sck  = phase;
                if (last) state_next = RDATA;
            end
            RDATA: begin
                ce_n = 1'b0;
                sck  = phase;
                if (last) state_next = DONE;
            end
            WDATA: begin
                ce_n   = 1'b0;
                sck    = phase;
                dio_oe = 1'b1;
                dio_o  = wd_sr[31:28];
                if (last) state_next = DONE;
            end
            DONE: begin
                pready     = 1'b1;
                pslverr    = err;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Burst control: sck phase, pulse counter, latched request and read result.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            phase  <= 1'b0;
            cnt    <= 8'd0;
            is_wr  <= 1'b0;
            err    <= 1'b0;
            wr_cnt <= 3'd0;
            prdata <= 32'h0;
        end else begin
            if (active) begin
                phase <= ~phase;
                if (phase) cnt <= last ? 8'd0 : cnt + 8'd1;
            end else begin
                phase <= 1'b0;
                cnt   <= 8'd0;
            end
            if (start) begin
                is_wr  <= pwrite;
                err    <= pwrite && !dec_ok;
                wr_cnt <= dec_cnt;
            end
            if (state == RDATA && !phase && cnt == 8'd7) begin
                prdata <= bswap({rd_sr[27:0], dio_i});
            end
        end
    end

    // Serialisers: shift on the sck falling edge, capture reads as sck rises.
    always_ff @(posedge clock) begin
        if (start) begin
            cmd_sr  <= pwrite ? 8'h38 : 8'hEB;
            addr_sr <= {paddr[ADDR_BITS-1:2], pwrite ? dec_start : 2'b00};
            wd_sr   <= bswap(pwdata >> {dec_start, 3'b000});
        end else if (phase) begin
            if (state == CMD)   cmd_sr  <= {cmd_sr[6:0], 1'b0};
            if (state == ADDR)  addr_sr <= {addr_sr[ADDR_BITS-5:0], 4'h0};
            if (state == WDATA) wd_sr   <= {wd_sr[27:0], 4'h0};
        end
        if (state == RDATA && !phase) rd_sr <= {rd_sr[27:0], dio_i};
    end

endmodule

// File: tb/tb_psram_ctrl_apb.sv
// Bench for psram_ctrl_apb: APB driver, behavioural QPI PSRAM model and
// a scoreboard queue of expected responses per transfer.
module tb_psram_ctrl_apb;

    localparam int RD_WAIT = 7;

    logic        clock = 1'b0;
    logic        resetn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        sck, ce_n, dio_oe;
    logic [3:0]  dio_o;
    logic [3:0]  dio_i = 4'h0;

    psram_ctrl_apb #(.ADDR_BITS(24), .RD_WAIT(RD_WAIT)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .pready  (pready),
        .prdata  (prdata),
        .pslverr (pslverr),
        .sck     (sck),
        .ce_n    (ce_n),
        .dio_o   (dio_o),
        .dio_oe  (dio_oe),
        .dio_i   (dio_i)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    // ---------------- PSRAM device model ----------------
    logic [7:0]  mem [int];
    int          m_rise, m_oe1, m_oe0, m_wcnt, ce_falls = 0;
    int          m_e, m_d, m_k, m_a;
    logic        m_bad;
    logic [7:0]  m_cmd, m_b;
    logic [23:0] m_addr;
    logic [31:0] m_wnib;

    function automatic logic [7:0] mem_rd(input int a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    always @(negedge ce_n) begin
        m_rise = 0; m_oe1 = 0; m_oe0 = 0; m_wcnt = 0; m_bad = 1'b0;
        m_cmd = 8'h0; m_addr = 24'h0; m_wnib = 32'h0; dio_i = 4'h0;
        ce_falls++;
    end

    always @(posedge sck) begin
        if (ce_n === 1'b0) begin
            m_e = m_rise;
            m_rise++;
            if (dio_oe === 1'b1) begin
                m_oe1++;
                if (m_oe0 != 0) m_bad = 1'b1;
            end else begin
                m_oe0++;
            end
            if (m_e < 8) begin
                m_cmd = {m_cmd[6:0], dio_o[0]};
            end else if (m_e < 14) begin
                m_addr = {m_addr[19:0], dio_o};
            end else if (m_cmd == 8'h38) begin
                m_d = m_e - 14;
                m_wnib = {m_wnib[27:0], dio_o};
                m_wcnt++;
                m_a = int'(m_addr) + m_d / 2;
                m_b = mem_rd(m_a);
                if (m_d % 2 == 0) m_b[7:4] = dio_o;
                else              m_b[3:0] = dio_o;
                mem[m_a] = m_b;
            end
            if (m_cmd == 8'hEB && m_e >= 13 + RD_WAIT && m_e < 21 + RD_WAIT) begin
                m_k = m_e - (13 + RD_WAIT);
                m_b = mem_rd(int'(m_addr) + m_k / 2);
                dio_i = (m_k % 2 == 0) ? m_b[7:4] : m_b[3:0];
            end
        end
    end

    // Whenever a response is presented the pins must be idle.
    always @(negedge clock) begin
        if (pready === 1'b1) begin
            checks++;
            if ({ce_n, sck, dio_oe} !== 3'b100) begin
                errors++;
                $display("FAIL done_pins: ce_n/sck/oe got %b expected 100", {ce_n, sck, dio_oe});
            end
        end
    end

    // ---------------- APB driver ----------------
    // Called #1 after a rising edge; returns #1 after the edge that ends the transfer.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output int lat);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        @(posedge clock); #1;
        penable = 1'b1;
        lat = -1; rdata = 32'hx; err = 1'bx;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clock); #1;
            if (pready === 1'b1) begin
                lat = c; rdata = prdata; err = pslverr;
                break;
            end
        end
        @(posedge clock); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({ce_n, sck, dio_oe, dio_o, pready, pslverr} !== 9'b1_0_0_0000_0_0) begin
            errors++;
            $display("FAIL reset_pins: got %b expected 100000000", {ce_n, sck, dio_oe, dio_o, pready, pslverr});
        end
        checks++;
        if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h expected 00000000", prdata); end
        resetn = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_full_write_read();
        logic [31:0] rd; logic er; int lt; exp_t ex;
        sb.push_back('{32'h0, 1'b0, 45});
        apb_xfer(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, rd, er, lt);
        ex = sb.pop_front();
        checks++; if (lt !== ex.lat) begin errors++; $display("FAIL wr_full_lat: got %0d expected %0d", lt, ex.lat); end
        checks++; if (er !== ex.err) begin errors++; $display("FAIL wr_full_err: got %b expected %b", er, ex.err); end
        checks++; if (m_cmd !== 8'h38) begin errors++; $display("FAIL wr_full_cmd: got %h expected 38", m_cmd); end
        checks++; if (m_addr !== 24'h000100) begin errors++; $display("FAIL wr_full_addr: got %h expected 000100", m_addr); end
        checks++; if (m_wnib !== 32'hEFBEADDE) begin errors++; $display("FAIL wr_full_nibbles: got %h expected efbeadde", m_wnib); end
        checks++; if (m_rise !== 22) begin errors++; $display("FAIL wr_full_pulses: got %0d expected 22", m_rise); end
        sb.push_back('{32'hDEAD_BEEF, 1'b0, 59});
        apb_xfer(1'b0, 32'h0000_0100, 32'h0, 4'b0000, rd, er, lt);
        ex = sb.pop_front();
        checks++; if (rd !== ex.data) begin errors++; $display("FAIL rd_full_data: got %h expected %h", rd, ex.data); end
        checks++; if (lt !== ex.lat) begin errors++; $display("FAIL rd_full_lat: got %0d expected %0d", lt, ex.lat); end
        checks++; if (m_cmd !== 8'hEB) begin errors++; $display("FAIL rd_full_cmd: got %h expected eb", m_cmd); end
    endtask

    task automatic test_partial_write();
        logic [31:0] rd; logic er; int lt; exp_t ex;
        sb.push_back('{32'h0, 1'b0, 33});
        apb_xfer(1'b1, 32'h0000_0100, 32'h00AB_0000, 4'b0100, rd, er, lt);
        ex = sb.pop_front();
        checks++; if (lt !== ex.lat) begin errors++; $display("FAIL wr_part_lat: got %0d expected %0d", lt, ex.lat); end
        checks++; if (m_addr !== 24'h000102) begin errors++; $display("FAIL wr_part_addr: got %h expected 000102", m_addr); end
        checks++; if (m_wcnt !== 2 || m_wnib !== 32'h0000_00AB) begin
            errors++; $display("FAIL wr_part_nibbles: got %0d/%h expected 2/000000ab", m_wcnt, m_wnib);
        end
        sb.push_back('{32'hDEAB_BEEF, 1'b0, 59});
        apb_xfer(1'b0, 32'h0000_0100, 32'h0, 4'b0000, rd, er, lt);
        ex = sb.pop_front();
        checks++; if (rd !== ex.data) begin errors++; $display("FAIL rd_part_data: got %h expected %h", rd, ex.data); end
    endtask

    task automatic test_error_strobe();
        logic [31:0] rd; logic er; int lt; exp_t ex; int falls;
        falls = ce_falls;
        sb.push_back('{32'h0, 1'b1, 1});
        apb_xfer(1'b1, 32'h0000_0100, 32'h1122_3344, 4'b0101, rd, er, lt);
        ex = sb.pop_front();
        checks++; if (er !== ex.err) begin errors++; $display("FAIL err_strb_slverr: got %b expected %b", er, ex.err); end
        checks++; if (lt !== ex.lat) begin errors++; $display("FAIL err_strb_lat: got %0d expected %0d", lt, ex.lat); end
        checks++; if (ce_falls !== falls) begin errors++; $display("FAIL err_strb_ce: got %0d expected %0d", ce_falls, falls); end
        sb.push_back('{32'h0, 1'b0, 1});
        apb_xfer(1'b1, 32'h0000_0100, 32'h5566_7788, 4'b0000, rd, er, lt);
        ex = sb.pop_front();
        checks++; if (er !== ex.err || lt !== ex.lat) begin
            errors++; $display("FAIL zero_strb: got err %b lat %0d expected err %b lat %0d", er, lt, ex.err, ex.lat);
        end
        checks++; if (ce_falls !== falls) begin errors++; $display("FAIL zero_strb_ce: got %0d expected %0d", ce_falls, falls); end
        sb.push_back('{32'hDEAB_BEEF, 1'b0, 59});
        apb_xfer(1'b0, 32'h0000_0100, 32'h0, 4'b0000, rd, er, lt);
        ex = sb.pop_front();
        checks++; if (rd !== ex.data) begin errors++; $display("FAIL err_strb_mem: got %h expected %h", rd, ex.data); end
    endtask

    task automatic test_read_timing();
        logic [31:0] rd; logic er; int lt; exp_t ex;
        sb.push_back('{32'hDEAB_BEEF, 1'b0, 59});
        apb_xfer(1'b0, 32'h0000_0103, 32'h0, 4'b0000, rd, er, lt);
        ex = sb.pop_front();
        checks++; if (lt !== ex.lat) begin errors++; $display("FAIL rd_tim_lat: got %0d expected %0d", lt, ex.lat); end
        checks++; if (rd !== ex.data || er !== ex.err) begin
            errors++; $display("FAIL rd_tim_data: got %h/%b expected %h/%b", rd, er, ex.data, ex.err);
        end
        checks++; if (m_addr !== 24'h000100) begin errors++; $display("FAIL rd_tim_addr: got %h expected 000100", m_addr); end
        checks++; if (m_oe1 !== 14 || m_oe0 !== 8 + RD_WAIT) begin
            errors++; $display("FAIL rd_tim_pulses: got oe1 %0d oe0 %0d expected 14 %0d", m_oe1, m_oe0, 8 + RD_WAIT);
        end
        checks++; if (m_bad !== 1'b0) begin errors++; $display("FAIL rd_tim_oe_order: got %b expected 0", m_bad); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rd; logic er; int lt; exp_t ex;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0100; pstrb = 4'h0;
        @(posedge clock); #1;
        penable = 1'b1;
        repeat (30) @(posedge clock);
        #1;
        checks++; if ({ce_n, sck} !== 2'b01) begin errors++; $display("FAIL mid_busy: ce_n/sck got %b expected 01", {ce_n, sck}); end
        #1;
        resetn = 1'b0;
        #1;
        checks++; if ({ce_n, sck, pready} !== 3'b100) begin
            errors++; $display("FAIL mid_reset_pins: ce_n/sck/pready got %b expected 100", {ce_n, sck, pready});
        end
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL mid_reset_prdata: got %h expected 00000000", prdata); end
        psel = 1'b0; penable = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        sb.push_back('{32'hDEAB_BEEF, 1'b0, 59});
        apb_xfer(1'b0, 32'h0000_0100, 32'h0, 4'b0000, rd, er, lt);
        ex = sb.pop_front();
        checks++; if (rd !== ex.data || lt !== ex.lat) begin
            errors++; $display("FAIL post_reset_read: got %h lat %0d expected %h lat %0d", rd, lt, ex.data, ex.lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lt; exp_t ex;
        sb.push_back('{32'h0, 1'b0, 45});
        apb_xfer(1'b1, 32'h0000_0200, 32'h1234_5678, 4'b1111, rd, er, lt);
        ex = sb.pop_front();
        checks++; if (lt !== ex.lat) begin errors++; $display("FAIL b2b_wr_lat: got %0d expected %0d", lt, ex.lat); end
        sb.push_back('{32'hDEAB_BEEF, 1'b0, 59});
        sb.push_back('{32'h1234_5678, 1'b0, 59});
        apb_xfer(1'b0, 32'h0000_0100, 32'h0, 4'b0000, rd, er, lt);
        ex = sb.pop_front();
        checks++; if (ce_n !== 1'b1) begin errors++; $display("FAIL b2b_gap_ce: got %b expected 1", ce_n); end
        checks++; if (rd !== ex.data || lt !== ex.lat) begin
            errors++; $display("FAIL b2b_rd1: got %h lat %0d expected %h lat %0d", rd, lt, ex.data, ex.lat);
        end
        apb_xfer(1'b0, 32'h0000_0200, 32'h0, 4'b0000, rd, er, lt);
        ex = sb.pop_front();
        checks++; if (rd !== ex.data || lt !== ex.lat) begin
            errors++; $display("FAIL b2b_rd2: got %h lat %0d expected %h lat %0d", rd, lt, ex.data, ex.lat);
        end
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_error_strobe();
        test_read_timing();
        test_reset_mid_read();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
